keccak_state_unloader: RTL and testbench

- Reads a 1600-bit Keccak state back out to the core, one lane (two 32-bit words) per handshake.
- It is the read-side counterpart of the indexed 64-bit-per-write state loader.
- On start, it snapshots the permutation output and streams lanes 0..N-1 with a valid/ready handshake.
- Typical use: N = rate in lanes (SHA3-256 = 17, SHAKE128 = 21) or 25 for a full state dump.

---
 rtl/keccak_state_unloader_if.sv | 36 +++
 rtl/keccak_state_unloader.sv | 147 ++++++++++++++
 tb/tb_keccak_state_unloader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_state_unloader_if.sv
// ---------------------------------------------------------------------------
// keccak_state_unloader_if
//   Output stream of the Keccak state unloader: one lane (two words) per
//   valid/ready handshake.
//   valid_o   : word_0_o, word_1_o and index_o carry a pair
//   ready_i   : consumer accepts the current pair
//   word_0_o  : low word of the lane (word index_o)
//   word_1_o  : high word of the lane (word index_o+1)
//   index_o   : even word index of the current pair, 0..48
//   The master modport is the unloader, the slave modport is the consumer.
// ---------------------------------------------------------------------------
interface keccak_state_unloader_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  valid_o;
    logic                  ready_i;
    logic [WORD_WIDTH-1:0] word_0_o;
    logic [WORD_WIDTH-1:0] word_1_o;
    logic [5:0]            index_o;

    modport master (
        output valid_o,
        output word_0_o,
        output word_1_o,
        output index_o,
        input  ready_i
    );

    modport slave (
        input  valid_o,
        input  word_0_o,
        input  word_1_o,
        input  index_o,
        output ready_i
    );
endinterface

// File: rtl/keccak_state_unloader.sv
// ---------------------------------------------------------------------------
// keccak_state_unloader
//   Snapshots a 1600-bit Keccak state on start and streams lanes 0..N-1 to
//   the core, one lane per handshake. N = num_lanes_i, with 0 or >25 meaning
//   a full 25-lane dump.
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   state_i     : Keccak state, word w at bits [32w+31:32w]
//   start_i     : begin an unload (only honoured in IDLE)
//   num_lanes_i : lanes to stream, sampled with start_i
//   clear_i     : synchronous abort back to IDLE (snapshot kept, no done)
//   busy_o      : high while streaming
//   done_o      : one-cycle pulse after the last pair transfers
//   bus         : stream handshake (valid/ready, word pair, index)
// ---------------------------------------------------------------------------
module keccak_state_unloader #(
    parameter int NUM_WORDS  = 50,
    parameter int WORD_WIDTH = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] state_i,
    input  logic                            start_i,
    input  logic [4:0]                      num_lanes_i,
    input  logic                            clear_i,
    output logic                            busy_o,
    output logic                            done_o,
    keccak_state_unloader_if.master         bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [4:0] MAX_LANES = 5'd25;

    state_t                                    r_state;
    state_t                                    w_next_state;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]      r_snapshot;
    logic [5:0]                                r_index;
    logic [5:0]                                r_last_idx;
    logic                                      r_done;

    logic                                      w_start_accept;
    logic                                      w_xfer;
    logic                                      w_last_xfer;
    logic [4:0]                                w_eff_lanes;
    logic [5:0]                                w_last_idx_calc;
    logic [5:0]                                w_index_hi;

    // Select one word of the snapshot by its word index.
    function automatic logic [WORD_WIDTH-1:0] pick_word(
        input logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] snap,
        input logic [5:0]                           idx
    );
        return snap[idx];
    endfunction

    // Lane count clamp and the even word index of the final pair.
    always_comb begin
        w_eff_lanes = MAX_LANES;
        if ((num_lanes_i == 5'd0) || (num_lanes_i > MAX_LANES)) begin
            w_eff_lanes = MAX_LANES;
        end else begin
            w_eff_lanes = num_lanes_i;
        end
        w_last_idx_calc = {w_eff_lanes - 5'd1, 1'b0};
    end

    // Handshake events and next-state logic; clear_i overrides everything.
    always_comb begin
        w_next_state   = r_state;
        w_start_accept = 1'b0;
        w_xfer         = 1'b0;
        w_last_xfer    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !clear_i) begin
                    w_start_accept = 1'b1;
                    w_next_state   = ST_STREAM;
                end else begin
                    w_next_state   = ST_IDLE;
                end
            end
            ST_STREAM: begin
                w_xfer      = bus.ready_i;
                w_last_xfer = bus.ready_i && (r_index == r_last_idx);
                if (clear_i) begin
                    w_next_state = ST_IDLE;
                end else if (w_last_xfer) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_STREAM;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Snapshot, pair index and done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_snapshot <= '0;
            r_index    <= 6'd0;
            r_last_idx <= 6'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_xfer && !clear_i;
            if (clear_i) begin
                r_index <= 6'd0;
            end else if (w_start_accept) begin
                r_snapshot <= state_i;
                r_last_idx <= w_last_idx_calc;
                r_index    <= 6'd0;
            end else if (w_last_xfer) begin
                r_index <= 6'd0;
            end else if (w_xfer) begin
                r_index <= r_index + 6'd2;
            end else begin
                r_index <= r_index;
            end
        end
    end

    // The index is always even, so its odd partner is just bit 0 set.
    assign w_index_hi   = r_index | 6'd1;

    assign bus.valid_o  = (r_state == ST_STREAM);
    assign bus.index_o  = r_index;
    assign bus.word_0_o = pick_word(r_snapshot, r_index);
    assign bus.word_1_o = pick_word(r_snapshot, w_index_hi);
    assign busy_o       = (r_state == ST_STREAM);
    assign done_o       = r_done;

endmodule

// File: tb/tb_keccak_state_unloader.sv
// ---------------------------------------------------------------------------
// tb_keccak_state_unloader
//   Directed bench for keccak_state_unloader: full dump, rate stream,
//   backpressure, snapshot isolation, abort, reset and restart on done.
// ---------------------------------------------------------------------------
module tb_keccak_state_unloader;

    logic          clk_i;
    logic          rst_ni;
    logic [1599:0] state_i;
    logic          start_i;
    logic [4:0]    num_lanes_i;
    logic          clear_i;
    logic          busy_o;
    logic          done_o;

    int n_checks;
    int n_fail;

    keccak_state_unloader_if #(.WORD_WIDTH(32)) bus ();

    keccak_state_unloader #(
        .NUM_WORDS  (50),
        .WORD_WIDTH (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .state_i     (state_i),
        .start_i     (start_i),
        .num_lanes_i (num_lanes_i),
        .clear_i     (clear_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bus         (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Fill state_i with word w = base + w.
    task automatic set_state(input logic [31:0] base);
        for (int w = 0; w < 50; w++) begin
            state_i[32*w +: 32] = base + 32'(w);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done_o); end
        n_checks++; if (bus.index_o !== 6'd0) begin n_fail++; $display("FAIL reset_index got %0d exp 0", bus.index_o); end
        n_checks++; if (bus.word_0_o !== 32'h0 || bus.word_1_o !== 32'h0) begin n_fail++; $display("FAIL reset_words got %h %h exp 0 0", bus.word_0_o, bus.word_1_o); end
        tick();
        tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_full_dump();
        set_state(32'hA500_0000);
        num_lanes_i = 5'd0;
        bus.ready_i = 1'b1;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        for (int k = 0; k < 25; k++) begin
            n_checks++; if (bus.valid_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL full_valid k=%0d got v=%b b=%b exp 1 1", k, bus.valid_o, busy_o); end
            n_checks++; if (bus.index_o !== 6'(2*k)) begin n_fail++; $display("FAIL full_index k=%0d got %0d exp %0d", k, bus.index_o, 2*k); end
            n_checks++; if (bus.word_0_o !== 32'hA500_0000 + 32'(2*k) || bus.word_1_o !== 32'hA500_0000 + 32'(2*k+1)) begin
                n_fail++; $display("FAIL full_words k=%0d got %h %h exp %h %h", k, bus.word_0_o, bus.word_1_o, 32'hA500_0000 + 32'(2*k), 32'hA500_0000 + 32'(2*k+1));
            end
            n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL full_early_done k=%0d got %b exp 0", k, done_o); end
            tick();
        end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL full_done got %b exp 1", done_o); end
        n_checks++; if (bus.valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL full_idle got v=%b b=%b exp 0 0", bus.valid_o, busy_o); end
        tick();
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL full_done_width got %b exp 0", done_o); end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_rate_stream();
        int cnt;
        int done_cycles;
        int max_idx;
        cnt         = 0;
        done_cycles = 0;
        max_idx     = 0;
        set_state(32'h5A00_0000);
        num_lanes_i = 5'd17;
        bus.ready_i = 1'b1;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.valid_o === 1'b1) begin
                n_checks++; if (bus.index_o !== 6'(2*cnt) || bus.word_0_o !== 32'h5A00_0000 + 32'(2*cnt) || bus.word_1_o !== 32'h5A00_0000 + 32'(2*cnt+1)) begin
                    n_fail++; $display("FAIL rate_pair n=%0d got idx=%0d %h %h exp idx=%0d", cnt, bus.index_o, bus.word_0_o, bus.word_1_o, 2*cnt);
                end
                if (int'(bus.index_o) > max_idx) max_idx = int'(bus.index_o);
                cnt++;
            end
            if (done_o === 1'b1) done_cycles++;
            tick();
        end
        n_checks++; if (cnt !== 17) begin n_fail++; $display("FAIL rate_count got %0d exp 17", cnt); end
        n_checks++; if (max_idx !== 32) begin n_fail++; $display("FAIL rate_last_index got %0d exp 32", max_idx); end
        n_checks++; if (done_cycles !== 1) begin n_fail++; $display("FAIL rate_done_cycles got %0d exp 1", done_cycles); end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [5:0] exp_idx [6];
        logic       rdy_seq [6];
        exp_idx = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd2, 6'd4};
        rdy_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        set_state(32'h1200_0000);
        num_lanes_i = 5'd3;
        bus.ready_i = 1'b0;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_checks++; if (bus.valid_o !== 1'b1 || bus.index_o !== exp_idx[c] || bus.word_0_o !== 32'h1200_0000 + 32'(exp_idx[c]) || bus.word_1_o !== 32'h1200_0001 + 32'(exp_idx[c])) begin
                n_fail++; $display("FAIL bp_hold c=%0d got v=%b idx=%0d %h %h exp idx=%0d", c, bus.valid_o, bus.index_o, bus.word_0_o, bus.word_1_o, exp_idx[c]);
            end
            n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL bp_early_done c=%0d got %b exp 0", c, done_o); end
            bus.ready_i = rdy_seq[c];
            tick();
        end
        n_checks++; if (done_o !== 1'b1 || bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_done got d=%b v=%b exp 1 0", done_o, bus.valid_o); end
        bus.ready_i = 1'b0;
        tick();
    endtask

    task automatic test_snapshot_isolation();
        set_state(32'h3C00_0000);
        num_lanes_i = 5'd4;
        bus.ready_i = 1'b1;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        state_i     = {1600{1'b1}};
        for (int k = 0; k < 4; k++) begin
            start_i = (k == 1);
            n_checks++; if (bus.valid_o !== 1'b1 || bus.index_o !== 6'(2*k) || bus.word_0_o !== 32'h3C00_0000 + 32'(2*k) || bus.word_1_o !== 32'h3C00_0000 + 32'(2*k+1)) begin
                n_fail++; $display("FAIL snap_pair k=%0d got v=%b idx=%0d %h %h exp idx=%0d", k, bus.valid_o, bus.index_o, bus.word_0_o, bus.word_1_o, 2*k);
            end
            tick();
        end
        start_i = 1'b0;
        n_checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL snap_done got d=%b b=%b exp 1 0", done_o, busy_o); end
        bus.ready_i = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        set_state(32'hC300_0000);
        num_lanes_i = 5'd0;
        bus.ready_i = 1'b1;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_checks++; if (bus.index_o !== 6'd10) begin n_fail++; $display("FAIL abort_reach got %0d exp 10", bus.index_o); end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_checks++; if (bus.valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || bus.index_o !== 6'd0) begin
            n_fail++; $display("FAIL abort_idle got v=%b b=%b d=%b idx=%0d exp 0 0 0 0", bus.valid_o, busy_o, done_o, bus.index_o);
        end
        tick();
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b exp 0", done_o); end
        set_state(32'h7700_0000);
        num_lanes_i = 5'd2;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (bus.valid_o !== 1'b1 || bus.index_o !== 6'(2*k) || bus.word_0_o !== 32'h7700_0000 + 32'(2*k) || bus.word_1_o !== 32'h7700_0000 + 32'(2*k+1)) begin
                n_fail++; $display("FAIL abort_restart k=%0d got v=%b idx=%0d %h %h exp idx=%0d", k, bus.valid_o, bus.index_o, bus.word_0_o, bus.word_1_o, 2*k);
            end
            tick();
        end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL abort_restart_done got %b exp 1", done_o); end
        bus.ready_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stream();
        set_state(32'hE100_0000);
        num_lanes_i = 5'd0;
        bus.ready_i = 1'b1;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        tick();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || bus.index_o !== 6'd0) begin
            n_fail++; $display("FAIL rst_mid_ctrl got v=%b b=%b d=%b idx=%0d exp 0 0 0 0", bus.valid_o, busy_o, done_o, bus.index_o);
        end
        n_checks++; if (bus.word_0_o !== 32'h0 || bus.word_1_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_words got %h %h exp 0 0", bus.word_0_o, bus.word_1_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (done_o !== 1'b0 || bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet k=%0d got d=%b v=%b exp 0 0", k, done_o, bus.valid_o); end
        end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_restart_on_done();
        set_state(32'h4400_0000);
        num_lanes_i = 5'd1;
        bus.ready_i = 1'b1;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        n_checks++; if (bus.valid_o !== 1'b1 || bus.index_o !== 6'd0) begin n_fail++; $display("FAIL rod_first got v=%b idx=%0d exp 1 0", bus.valid_o, bus.index_o); end
        tick();
        n_checks++; if (done_o !== 1'b1 || bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rod_done got d=%b v=%b exp 1 0", done_o, bus.valid_o); end
        set_state(32'h8800_0000);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++; if (bus.valid_o !== 1'b1 || bus.index_o !== 6'd0 || done_o !== 1'b0 || bus.word_0_o !== 32'h8800_0000 || bus.word_1_o !== 32'h8800_0001) begin
            n_fail++; $display("FAIL rod_restart got v=%b idx=%0d d=%b %h %h exp 1 0 0 88000000 88000001", bus.valid_o, bus.index_o, done_o, bus.word_0_o, bus.word_1_o);
        end
        tick();
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL rod_second_done got %b exp 1", done_o); end
        bus.ready_i = 1'b0;
        tick();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_ni      = 1'b0;
        state_i     = '0;
        start_i     = 1'b0;
        num_lanes_i = 5'd0;
        clear_i     = 1'b0;
        bus.ready_i = 1'b0;
        test_reset();
        test_full_dump();
        test_rate_stream();
        test_backpressure();
        test_snapshot_isolation();
        test_abort();
        test_reset_mid_stream();
        test_restart_on_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
